// File: rtl/pulse_meter_if.sv
`default_nettype none
// ============================================================================
// Module  : pulse_meter_if
// Brief   : Bundles the pulse input and measurement results of pulse_meter.
// Rev     : 1.0  initial release
// ============================================================================
interface pulse_meter_if #(
  parameter int CNT_W = 8
);
  logic             signal;
  logic             level;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             overflow;

  modport master (
    output signal,
    input  level, width, period, valid, overflow
  );

  modport slave (
    input  signal,
    output level, width, period, valid, overflow
  );
endinterface
`default_nettype wire

// File: rtl/pulse_meter.sv
`default_nettype none
// ============================================================================
// Module  : pulse_meter
// Brief   : Measures high width and rise-to-rise period of a pulse train in
//           clock cycles; optional input synchroniser via PULSE_METER_SYNC_EN.
// Rev     : 1.0  initial release
// ============================================================================
module pulse_meter #(
  parameter int CNT_W = 8
) (
  input  wire logic     clock,
  input  wire logic     reset,
  pulse_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  logic             w_sample;
  logic             s_q;
  logic             s_prev_q;
  logic             w_rise;
  logic             w_fall;

  state_t           state_q;
  logic [CNT_W-1:0] hi_cnt_q;
  logic [CNT_W-1:0] per_cnt_q;
  logic             ovf_q;
  logic [CNT_W-1:0] hi_cnt_d;
  logic [CNT_W-1:0] per_cnt_d;

  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] period_q;
  logic             valid_q;
  logic             overflow_q;

`ifdef PULSE_METER_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.signal;
      sync2_q <= sync1_q;
    end
  end

  assign w_sample = sync2_q;
`else
  assign w_sample = bus.signal;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      s_q      <= w_sample;
      s_prev_q <= s_q;
    end
  end

  assign w_rise = s_q & ~s_prev_q;
  assign w_fall = ~s_q & s_prev_q;

  // Saturating increments: counters park at the cap instead of wrapping.
  always_comb begin
    hi_cnt_d  = (hi_cnt_q  == c_cnt_max) ? hi_cnt_q  : hi_cnt_q  + c_cnt_one;
    per_cnt_d = (per_cnt_q == c_cnt_max) ? per_cnt_q : per_cnt_q + c_cnt_one;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hi_cnt_q   <= '0;
      per_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      width_q    <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_rise) begin
            state_q   <= ST_HIGH;
            hi_cnt_q  <= c_cnt_one;
            per_cnt_q <= c_cnt_one;
            ovf_q     <= 1'b0;
          end
        end
        ST_HIGH: begin
          per_cnt_q <= per_cnt_d;
          if (w_fall) begin
            state_q <= ST_LOW;
            if (per_cnt_d == c_cnt_max) ovf_q <= 1'b1;
          end else begin
            hi_cnt_q <= hi_cnt_d;
            if ((hi_cnt_d == c_cnt_max) || (per_cnt_d == c_cnt_max)) ovf_q <= 1'b1;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            valid_q    <= 1'b1;
            width_q    <= hi_cnt_q;
            period_q   <= per_cnt_q;
            overflow_q <= ovf_q;
            state_q    <= ST_HIGH;
            hi_cnt_q   <= c_cnt_one;
            per_cnt_q  <= c_cnt_one;
            ovf_q      <= 1'b0;
          end else begin
            per_cnt_q <= per_cnt_d;
            if (per_cnt_d == c_cnt_max) ovf_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.level    = s_q;
  assign bus.width    = width_q;
  assign bus.period   = period_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = overflow_q;

endmodule
`default_nettype wire
